// File: rtl/ct_had_pipefifo_ctrl.sv
// HAD pipe-trace capture/readout sequencer: arms capture, stops on debug entry or trigger plus post window, serves host reads.
// Latency: write/stop act on the next edge; read pulses issue one cycle after the request (dbg may defer while pending).
// Backpressure: pipefifo reads win arbitration; one dbg read is held pending, further ones are dropped and flagged.
// Optional macro HAD_PIPEFIFO_CAPCNT_EN adds a saturating capture-cycle counter readable at [31:16].
module ct_had_pipefifo_ctrl #(
    parameter int DEPTH  = 16,
    parameter int POST_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic        cpuclk,
    input  logic        cpurst,
    input  logic        x_sm_xx_update_dr_en,
    input  logic        ir_xx_pipectrl_reg_sel,
    input  logic [63:0] ir_xx_wdata,
    input  logic        x_pipefifo_rd_req,
    input  logic        x_dbgfifo_rd_req,
    input  logic        had_trig_hit,
    input  logic        x_dbg_ack_pc,
    output logic        ctrl_pipefifo_wen,
    output logic        ctrl_pipefifo_ren,
    output logic        ctrl_dbgfifo_ren,
    output logic [31:0] pipectrl_regs_data,
    output logic        pipectrl_frozen
);

    localparam int RD_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CAPT   = 2'd1,
        POST   = 2'd2,
        FROZEN = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              stop_dbg_en;
    logic              stop_trig_en;
    logic [POST_W-1:0] post_cfg;
    logic [POST_W-1:0] rem;
    logic [RD_W-1:0]   rd_cnt;
    logic              rd_err;
    logic              dbg_ovf;
    logic              pending;
    logic              pipe_ren_q;
    logic              dbg_ren_q;
    logic [15:0]       cap_field;

    logic wr_hit;
    logic soft_clr;
    logic arm;
    logic at_rest;
    logic arm_go;
    logic stop;
    logic pipe_acc;
    logic dbg_issue;
    logic drained;
    logic unused_wdata;

    assign wr_hit   = x_sm_xx_update_dr_en & ir_xx_pipectrl_reg_sel;
    assign soft_clr = wr_hit & ir_xx_wdata[31];
    // soft_clr takes priority over arm in the same write
    assign arm      = wr_hit & ir_xx_wdata[0] & ~ir_xx_wdata[31];
    assign at_rest  = (state == IDLE) || (state == FROZEN);
    assign arm_go   = arm & at_rest;
    assign stop     = (stop_dbg_en & x_dbg_ack_pc) | (stop_trig_en & had_trig_hit);

    // Pipe reads are only legal while the FIFO is not being written
    assign pipe_acc  = x_pipefifo_rd_req & at_rest;
    // A dbg read goes out unless a pipe read owns the next cycle; a soft clear drops a held one
    assign dbg_issue = ~pipe_acc & ((pending & ~soft_clr) | x_dbgfifo_rd_req);
    assign drained   = (rd_cnt == RD_W'(DEPTH));

    assign unused_wdata = ^{ir_xx_wdata[63:32], ir_xx_wdata[30:12], ir_xx_wdata[3]};

    // State register
    always_ff @(posedge cpuclk) begin
        if (cpurst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (soft_clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, FROZEN: begin
                    if (arm) state_nxt = CAPT;
                end
                CAPT: begin
                    if (stop) state_nxt = (post_cfg == '0) ? FROZEN : POST;
                end
                POST: begin
                    if (rem == POST_W'(1)) state_nxt = FROZEN;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Configuration fields are refreshed by every PIPECTRL write
    always_ff @(posedge cpuclk) begin
        if (cpurst) begin
            stop_dbg_en  <= 1'b0;
            stop_trig_en <= 1'b0;
            post_cfg     <= '0;
        end else if (wr_hit) begin
            stop_dbg_en  <= ir_xx_wdata[1];
            stop_trig_en <= ir_xx_wdata[2];
            post_cfg     <= ir_xx_wdata[4 +: POST_W];
        end
    end

    // Post-trigger window: loaded on the stop cycle, counted down while in POST
    always_ff @(posedge cpuclk) begin
        if (cpurst || soft_clr) begin
            rem <= '0;
        end else if (state == CAPT && stop) begin
            rem <= post_cfg;
        end else if (state == POST) begin
            rem <= rem - POST_W'(1);
        end
    end

    // Read arbitration, pending dbg slot and sticky error flags
    always_ff @(posedge cpuclk) begin
        if (cpurst) begin
            pipe_ren_q <= 1'b0;
            dbg_ren_q  <= 1'b0;
            pending    <= 1'b0;
            rd_err     <= 1'b0;
            dbg_ovf    <= 1'b0;
        end else begin
            pipe_ren_q <= pipe_acc;
            dbg_ren_q  <= dbg_issue;
            pending    <= ~soft_clr & pipe_acc & (pending | x_dbgfifo_rd_req);
            rd_err     <= ~soft_clr & (rd_err | (x_pipefifo_rd_req & ~at_rest));
            dbg_ovf    <= ~soft_clr & (dbg_ovf | (x_dbgfifo_rd_req & pending));
        end
    end

    // Count issued pipe reads, saturating at the FIFO depth
    always_ff @(posedge cpuclk) begin
        if (cpurst || soft_clr || arm_go) begin
            rd_cnt <= '0;
        end else if (pipe_ren_q && !drained) begin
            rd_cnt <= rd_cnt + RD_W'(1);
        end
    end

`ifdef HAD_PIPEFIFO_CAPCNT_EN
    logic [CNT_W-1:0] capcnt;

    // Count capture-enable cycles, saturating at all-ones
    always_ff @(posedge cpuclk) begin
        if (cpurst || soft_clr || arm_go) begin
            capcnt <= '0;
        end else if (ctrl_pipefifo_wen && capcnt != {CNT_W{1'b1}}) begin
            capcnt <= capcnt + CNT_W'(1);
        end
    end

    assign cap_field = 16'(capcnt);
`else
    assign cap_field = 16'd0;
`endif

    // Outputs decoded from registered state only
    always_comb begin
        ctrl_pipefifo_wen  = (state == CAPT) || (state == POST);
        pipectrl_frozen    = (state == FROZEN);
        ctrl_pipefifo_ren  = pipe_ren_q;
        ctrl_dbgfifo_ren   = dbg_ren_q;
        pipectrl_regs_data = {cap_field, 8'(rem), 2'b00, pending, drained,
                              dbg_ovf, rd_err, state};
    end

endmodule
